// File: rtl/param_traffic_light_controller.sv
// Parametrised intersection controller with built-in prescaler and phase timer,
// pedestrian latching and car-sensor green extension. Define FLASH_MODE_EN for the flash override.
module param_traffic_light_controller #(
  parameter int TW          = 4,
  parameter int CLK_PER_SEC = 2,
  parameter int T_PED       = 15,
  parameter int T_GREEN     = 10,
  parameter int T_YELLOW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          car_ns,
  input  logic          car_ew,
  input  logic          ped,
`ifdef FLASH_MODE_EN
  input  logic          flash,
`endif
  output logic [2:0]    light_ns,
  output logic [2:0]    light_ew,
  output logic [1:0]    light_ped,
  output logic [2:0]    state_out,
  output logic [TW-1:0] timer_out
);

  generate
    if (TW < 1 || CLK_PER_SEC < 1 || T_PED > (1 << TW) - 1 ||
        T_GREEN > (1 << TW) - 1 || T_YELLOW > (1 << TW) - 1) begin : g_param_check
      $error("param_traffic_light_controller: phase durations must fit in TW bits and CLK_PER_SEC >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PED       = 3'd1,
    S_NS_GREEN  = 3'd2,
    S_NS_YELLOW = 3'd3,
    S_EW_GREEN  = 3'd4,
`ifdef FLASH_MODE_EN
    S_EW_YELLOW = 3'd5,
    S_FLASH     = 3'd6
`else
    S_EW_YELLOW = 3'd5
`endif
  } state_t;

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_PER_SEC - 1);
  localparam logic [TW-1:0] DUR_PED    = TW'(T_PED);
  localparam logic [TW-1:0] DUR_GREEN  = TW'(T_GREEN);
  localparam logic [TW-1:0] DUR_YELLOW = TW'(T_YELLOW);

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          ped_pend_reg, ped_pend_next;
  logic          ext_reg, ext_next;
  logic          tick, phase_done, extend;
  logic [1:0][2:0] light_next;
  logic [1:0]    light_ped_next;
`ifdef FLASH_MODE_EN
  logic          flash_on_reg, flash_on_next;
`endif

  function automatic logic [TW-1:0] phase_len(input state_t s);
    case (s)
      S_PED:                  phase_len = DUR_PED;
      S_NS_GREEN, S_EW_GREEN:   phase_len = DUR_GREEN;
      S_NS_YELLOW, S_EW_YELLOW: phase_len = DUR_YELLOW;
      default:                phase_len = '0;
    endcase
  endfunction

  assign tick       = (presc_reg == PRESC_MAX);
  assign phase_done = (timer_reg == '0);

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    presc_next    = tick ? '0 : presc_reg + PW'(1);
    ext_next      = ext_reg;
    ped_pend_next = ped_pend_reg | (ped && state_reg != S_PED);
    extend        = 1'b0;
    if (tick && !phase_done)
      timer_next = timer_reg - TW'(1);

    case (state_reg)
      S_IDLE:      if (phase_done) state_next = S_PED;
      S_PED:       if (phase_done) state_next = S_NS_GREEN;
      S_NS_GREEN:
        if (phase_done) begin
          if (car_ns && !car_ew && !ped_pend_reg && !ext_reg) extend = 1'b1;
          else state_next = S_NS_YELLOW;
        end
      S_NS_YELLOW: if (phase_done) state_next = S_EW_GREEN;
      S_EW_GREEN:
        if (phase_done) begin
          if (car_ew && !car_ns && !ped_pend_reg && !ext_reg) extend = 1'b1;
          else state_next = S_EW_YELLOW;
        end
      S_EW_YELLOW: if (phase_done) state_next = ped_pend_reg ? S_PED : S_NS_GREEN;
`ifdef FLASH_MODE_EN
      S_FLASH:     state_next = S_FLASH;
`endif
      default:     state_next = S_IDLE;
    endcase

`ifdef FLASH_MODE_EN
    if (flash) state_next = S_FLASH;
    else if (state_reg == S_FLASH) state_next = S_IDLE;
`endif

    if (extend) begin
      timer_next = DUR_GREEN;
      presc_next = '0;
      ext_next   = 1'b1;
    end

    // Any state change restarts the phase timer and forfeits the extension.
    if (state_next != state_reg) begin
      timer_next = phase_len(state_next);
      presc_next = '0;
      ext_next   = 1'b0;
      if (state_next == S_PED) ped_pend_next = 1'b0;
    end
  end

`ifdef FLASH_MODE_EN
  always_comb begin
    flash_on_next = 1'b0;
    if (state_next == S_FLASH)
      flash_on_next = (state_reg != S_FLASH) ? 1'b1 : (flash_on_reg ^ tick);
  end
`endif

  // Lights are decoded from the next state so the registered outputs line up with state_reg.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dir
      localparam logic [2:0] GREEN_CODE  = (gi == 0) ? 3'd2 : 3'd4;
      localparam logic [2:0] YELLOW_CODE = GREEN_CODE + 3'd1;
      assign light_next[gi] = (state_next == GREEN_CODE)  ? 3'b100 :
                              (state_next == YELLOW_CODE) ? 3'b010 :
`ifdef FLASH_MODE_EN
                              (state_next == S_FLASH) ? (flash_on_next ? 3'b010 : 3'b000) :
`endif
                              3'b001;
    end
  endgenerate

  assign light_ped_next = (state_next == S_PED) ? 2'b11 : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      presc_reg    <= '0;
      ped_pend_reg <= 1'b0;
      ext_reg      <= 1'b0;
      light_ns     <= 3'b001;
      light_ew     <= 3'b001;
      light_ped    <= 2'b00;
`ifdef FLASH_MODE_EN
      flash_on_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      presc_reg    <= presc_next;
      ped_pend_reg <= ped_pend_next;
      ext_reg      <= ext_next;
      light_ns     <= light_next[0];
      light_ew     <= light_next[1];
      light_ped    <= light_ped_next;
`ifdef FLASH_MODE_EN
      flash_on_reg <= flash_on_next;
`endif
    end
  end

  assign state_out = state_reg;
  assign timer_out = timer_reg;

endmodule

// File: tb/tb_param_traffic_light_controller.sv
// Self-checking bench: phase-sequence vector table, hand-written corner sequences,
// then randomized car/ped traffic checked cycle by cycle against a dwell-count model.
module tb_param_traffic_light_controller;
  localparam int C  = 2;
  localparam int TP = 15;
  localparam int TG = 10;
  localparam int TY = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic car_ns = 1'b0, car_ew = 1'b0, ped = 1'b0;
`ifdef FLASH_MODE_EN
  logic flash = 1'b0;
`endif
  logic [2:0] light_ns, light_ew, state_out;
  logic [1:0] light_ped;
  logic [3:0] timer_out;
  logic [2:0] l5_ns, l5_ew, s5;
  logic [1:0] l5_ped;
  logic [4:0] t5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_traffic_light_controller dut (
    .clk(clk), .rst(rst), .car_ns(car_ns), .car_ew(car_ew), .ped(ped),
`ifdef FLASH_MODE_EN
    .flash(flash),
`endif
    .light_ns(light_ns), .light_ew(light_ew), .light_ped(light_ped),
    .state_out(state_out), .timer_out(timer_out)
  );

  param_traffic_light_controller #(.TW(5), .CLK_PER_SEC(1), .T_GREEN(20)) u5 (
    .clk(clk), .rst(rst), .car_ns(1'b0), .car_ew(1'b0), .ped(1'b0),
`ifdef FLASH_MODE_EN
    .flash(1'b0),
`endif
    .light_ns(l5_ns), .light_ew(l5_ew), .light_ped(l5_ped),
    .state_out(s5), .timer_out(t5)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int st, input string name);
    int n = 0;
    while (int'(state_out) != st && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(state_out), st);
  endtask

  task automatic dwell(input int st, output int n);
    n = 0;
    while (int'(state_out) == st && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Reference model: phase number plus cycles elapsed since the phase (re)started.
  int m_ph, m_k, m_pend, m_ext;

  function automatic int dur(input int ph);
    case (ph)
      1:       return TP;
      2, 4:    return TG;
      3, 5:    return TY;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_ns(input int ph);
    return (ph == 2) ? 4 : (ph == 3) ? 2 : 1;
  endfunction

  function automatic int exp_ew(input int ph);
    return (ph == 4) ? 4 : (ph == 5) ? 2 : 1;
  endfunction

  task automatic model_step(input int cn, input int ce, input int p);
    int nph = m_ph;
    int npend = (m_pend != 0 || (p != 0 && m_ph != 1)) ? 1 : 0;
    if (m_k == dur(m_ph) * C) begin
      case (m_ph)
        0: nph = 1;
        1: nph = 2;
        2: if (cn && !ce && !m_pend && !m_ext) begin m_k = -1; m_ext = 1; end else nph = 3;
        3: nph = 4;
        4: if (ce && !cn && !m_pend && !m_ext) begin m_k = -1; m_ext = 1; end else nph = 5;
        5: nph = m_pend ? 1 : 2;
        default: nph = 0;
      endcase
    end
    m_k++;
    if (nph != m_ph) begin
      m_k = 0;
      m_ext = 0;
      if (nph == 1) npend = 0;
    end
    m_ph = nph;
    m_pend = npend;
  endtask

  typedef struct {
    int cn, ce, p, adv, st, ns, ew, pl, tm;
  } vec_t;
  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;

    vecs[0]  = '{0, 0, 0, 0,  0, 1, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 1,  1, 1, 1, 3, 15};
    vecs[2]  = '{0, 0, 0, 1,  1, 1, 1, 3, 15};
    vecs[3]  = '{0, 0, 0, 1,  1, 1, 1, 3, 14};
    vecs[4]  = '{0, 0, 0, 28, 1, 1, 1, 3, 0};
    vecs[5]  = '{0, 0, 0, 1,  2, 4, 1, 0, 10};
    vecs[6]  = '{0, 0, 0, 20, 2, 4, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 1,  3, 2, 1, 0, 5};
    vecs[8]  = '{0, 0, 0, 10, 3, 2, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 1,  4, 1, 4, 0, 10};
    vecs[10] = '{0, 0, 0, 20, 4, 1, 4, 0, 0};
    vecs[11] = '{0, 0, 0, 1,  5, 1, 2, 0, 5};
    vecs[12] = '{0, 0, 0, 10, 5, 1, 2, 0, 0};
    vecs[13] = '{0, 0, 0, 1,  2, 4, 1, 0, 10};

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Default phase sequence after reset release.
    for (int i = 0; i < 14; i++) begin
      car_ns = vecs[i].cn[0];
      car_ew = vecs[i].ce[0];
      ped    = vecs[i].p[0];
      repeat (vecs[i].adv) @(negedge clk);
      check("vec_state", int'(state_out), vecs[i].st);
      check("vec_ns",    int'(light_ns),  vecs[i].ns);
      check("vec_ew",    int'(light_ew),  vecs[i].ew);
      check("vec_ped",   int'(light_ped), vecs[i].pl);
      check("vec_timer", int'(timer_out), vecs[i].tm);
      $display("vec %0d: state=%0d ns=%b ew=%b ped=%b timer=%0d", i,
               state_out, light_ns, light_ew, light_ped, timer_out);
    end

    // One extension only while NS alone has traffic.
    car_ns = 1'b1; car_ew = 1'b0;
    dwell(2, n);
    check("ext_dwell", n, 2 * (TG * C + 1));
    check("ext_next_state", int'(state_out), 3);
    $display("ext: ns green dwell %0d cycles", n);
    car_ew = 1'b1;
    wait_state(2, "wait_ns_green_both");
    dwell(2, n);
    check("noext_dwell", n, TG * C + 1);
    $display("no-ext: ns green dwell %0d cycles", n);
    car_ns = 1'b0; car_ew = 1'b0;

    // Pedestrian pulse during NS green is served after EW yellow, then cleared.
    wait_state(2, "wait_ns_green_ped");
    repeat (3) @(negedge clk);
    ped = 1'b1;
    @(negedge clk);
    ped = 1'b0;
    wait_state(5, "wait_ew_yellow_ped");
    dwell(5, n);
    check("ped_served_state", int'(state_out), 1);
    check("ped_served_walk", int'(light_ped), 3);
    dwell(1, n);
    check("ped_dwell", n, TP * C + 1);
    $display("ped: served, dwell %0d cycles", n);
    wait_state(5, "wait_ew_yellow_clear");
    dwell(5, n);
    check("ped_cleared_next", int'(state_out), 2);

    // Asynchronous reset mid EW green.
    wait_state(4, "wait_ew_green_rst");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_ns", int'(light_ns), 1);
    check("arst_ew", int'(light_ew), 1);
    check("arst_ped", int'(light_ped), 0);
    check("arst_state", int'(state_out), 0);
    check("arst_timer", int'(timer_out), 0);
    $display("arst: state=%0d ns=%b ew=%b ped=%b", state_out, light_ns, light_ew, light_ped);
    @(negedge clk);
    rst = 1'b1;
    check("arst_idle", int'(state_out), 0);
    @(negedge clk);
    check("arst_then_ped", int'(state_out), 1);

    // Overridden instance: 1 clock per second, 20 s green.
    n = 0;
    while (s5 != 3'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("p5_reach_green", int'(s5), 2);
    n = 0; bad = 0;
    while (s5 == 3'd2 && n < 100) begin
      if (int'(t5) != 20 - n) bad++;
      n++;
      @(negedge clk);
    end
    check("p5_timer_seq_errors", bad, 0);
    check("p5_green_dwell", n, 21);
    check("p5_next_state", int'(s5), 3);
    $display("override: green dwell %0d cycles, timer errors %0d", n, bad);

`ifdef FLASH_MODE_EN
    wait_state(1, "wait_ped_flash");
    flash = 1'b1;
    @(negedge clk);
    check("flash_state", int'(state_out), 6);
    check("flash_ns_on", int'(light_ns), 2);
    check("flash_ew_on", int'(light_ew), 2);
    check("flash_ped", int'(light_ped), 0);
    @(negedge clk);
    check("flash_ns_on2", int'(light_ns), 2);
    @(negedge clk);
    check("flash_ns_off", int'(light_ns), 0);
    check("flash_ew_off", int'(light_ew), 0);
    repeat (2) @(negedge clk);
    check("flash_ns_on3", int'(light_ns), 2);
    flash = 1'b0;
    @(negedge clk);
    check("flash_exit_idle", int'(state_out), 0);
    $display("flash: exited to state %0d", state_out);
`endif

    // Randomized traffic against the model.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_ph = 0; m_k = 0; m_pend = 0; m_ext = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      int prev_ph, etm;
      etm = dur(m_ph) - m_k / C;
      checks++;
      if (int'(state_out) != m_ph || int'(timer_out) != etm ||
          int'(light_ns) != exp_ns(m_ph) || int'(light_ew) != exp_ew(m_ph) ||
          int'(light_ped) != ((m_ph == 1) ? 3 : 0)) begin
        errors++;
        $display("FAIL rand cyc %0d: got state=%0d timer=%0d ns=%0d ew=%0d ped=%0d, expected state=%0d timer=%0d ns=%0d ew=%0d ped=%0d",
                 cyc, state_out, timer_out, light_ns, light_ew, light_ped,
                 m_ph, etm, exp_ns(m_ph), exp_ew(m_ph), (m_ph == 1) ? 3 : 0);
      end
      if (cyc % 25 == 0) begin
        car_ns = 1'($urandom_range(0, 1));
        car_ew = 1'($urandom_range(0, 1));
      end
      ped = ($urandom_range(0, 15) == 0);
      prev_ph = m_ph;
      model_step(int'(car_ns), int'(car_ew), int'(ped));
      if (m_ph != prev_ph)
        $display("rand cyc %0d: phase %0d -> %0d (ext=%0d pend=%0d)", cyc, prev_ph, m_ph, m_ext, m_pend);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
